// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall and EX/MEM, MEM/WB operand forwarding (build macro FORWARDING_EN).
// Latency: one cycle from decode inputs to stage outputs; forwarded operands are muxed combinationally after the register.
// Backpressure: o_stall holds IF/ID and loads a bubble; i_flush overrides stall and also loads a bubble.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic [4:0]  i_rs_addr,
  input  logic [4:0]  i_rt_addr,
  input  logic [4:0]  i_rd_addr,
  input  logic [31:0] i_rs_data,
  input  logic [31:0] i_rt_data,
  input  logic [31:0] i_imm,
  input  logic [3:0]  i_alu_sel,
  input  logic        i_use_imm,
  input  logic        i_reg_write,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_flush,
  input  logic [4:0]  i_exmem_rd,
  input  logic        i_exmem_reg_write,
  input  logic [31:0] i_exmem_result,
  input  logic [4:0]  i_memwb_rd,
  input  logic        i_memwb_reg_write,
  input  logic [31:0] i_memwb_result,
  output logic        o_stall,
  output logic        o_valid,
  output logic [31:0] o_op1,
  output logic [31:0] o_op2,
  output logic [3:0]  o_alu_sel,
  output logic [4:0]  o_rd_addr,
  output logic        o_reg_write,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic [31:0] o_store_data
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [3:0]  alu_sel;
    logic        use_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } stage_t;

  stage_t      stage_q;
  stage_t      stage_d;
  logic        rt_used;
  logic        hazard;
  logic        stall;
  logic [31:0] rs_fwd;
  logic [31:0] rt_fwd;

  // Stores read rt even when the ALU takes the immediate.
  assign rt_used = ~i_use_imm | i_mem_write;

`ifdef FORWARDING_EN
  logic load_in_stage;

  // Only a load still in EX cannot be forwarded in time.
  assign load_in_stage = stage_q.valid & stage_q.mem_read & (stage_q.rd_addr != 5'd0);
  assign hazard = i_valid & load_in_stage &
                  ((stage_q.rd_addr == i_rs_addr) | (rt_used & (stage_q.rd_addr == i_rt_addr)));

  always_comb begin
    rs_fwd = stage_q.rs_data;
    if (stage_q.rs_addr != 5'd0 && i_exmem_reg_write && i_exmem_rd == stage_q.rs_addr)
      rs_fwd = i_exmem_result;
    else if (stage_q.rs_addr != 5'd0 && i_memwb_reg_write && i_memwb_rd == stage_q.rs_addr)
      rs_fwd = i_memwb_result;
  end

  always_comb begin
    rt_fwd = stage_q.rt_data;
    if (stage_q.rt_addr != 5'd0 && i_exmem_reg_write && i_exmem_rd == stage_q.rt_addr)
      rt_fwd = i_exmem_result;
    else if (stage_q.rt_addr != 5'd0 && i_memwb_reg_write && i_memwb_rd == stage_q.rt_addr)
      rt_fwd = i_memwb_result;
  end
`else
  logic rs_hit;
  logic rt_hit;
  logic unused_wb_results;

  // Without forwarding, any in-flight writer of a used source must drain first.
  assign rs_hit = (i_rs_addr != 5'd0) &
                  ((stage_q.valid & stage_q.reg_write & (stage_q.rd_addr == i_rs_addr)) |
                   (i_exmem_reg_write & (i_exmem_rd == i_rs_addr)) |
                   (i_memwb_reg_write & (i_memwb_rd == i_rs_addr)));
  assign rt_hit = (i_rt_addr != 5'd0) &
                  ((stage_q.valid & stage_q.reg_write & (stage_q.rd_addr == i_rt_addr)) |
                   (i_exmem_reg_write & (i_exmem_rd == i_rt_addr)) |
                   (i_memwb_reg_write & (i_memwb_rd == i_rt_addr)));
  assign hazard = i_valid & (rs_hit | (rt_used & rt_hit));

  assign rs_fwd = stage_q.rs_data;
  assign rt_fwd = stage_q.rt_data;
  assign unused_wb_results = ^{i_exmem_result, i_memwb_result};
`endif

  // Flush wins over stall; reset also masks it so IF/ID is never held in reset.
  assign stall = hazard & ~i_flush & rst_n;

  always_comb begin
    stage_d = '0;
    if (i_valid && !i_flush && !stall) begin
      stage_d.valid     = 1'b1;
      stage_d.rs_addr   = i_rs_addr;
      stage_d.rt_addr   = i_rt_addr;
      stage_d.rd_addr   = i_rd_addr;
      stage_d.rs_data   = i_rs_data;
      stage_d.rt_data   = i_rt_data;
      stage_d.imm       = i_imm;
      stage_d.alu_sel   = i_alu_sel;
      stage_d.use_imm   = i_use_imm;
      stage_d.reg_write = i_reg_write;
      stage_d.mem_read  = i_mem_read;
      stage_d.mem_write = i_mem_write;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stage_q <= '0;
    else
      stage_q <= stage_d;
  end

  assign o_stall      = stall;
  assign o_valid      = stage_q.valid;
  assign o_op1        = rs_fwd;
  assign o_op2        = stage_q.use_imm ? stage_q.imm : rt_fwd;
  assign o_store_data = rt_fwd;
  assign o_alu_sel    = stage_q.alu_sel;
  assign o_rd_addr    = stage_q.rd_addr;
  assign o_reg_write  = stage_q.reg_write;
  assign o_mem_read   = stage_q.mem_read;
  assign o_mem_write  = stage_q.mem_write;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have decode-side inputs: i_valid 1; i_rs_addr, i_rt_addr, i_rd_addr 5 each; i_rs_data, i_rt_data, i_imm 32 each; i_alu_sel 4 (ALU select code); i_use_imm 1; i_reg_write, i_mem_read, i_mem_write 1 each; i_flush 1.
REQ-003 SHALL have writeback-side inputs: i_exmem_rd 5, i_exmem_reg_write 1, i_exmem_result 32; i_memwb_rd 5, i_memwb_reg_write 1, i_memwb_result 32.
REQ-004 SHALL have outputs: o_stall 1 (hold IF/ID); o_valid 1; o_op1, o_op2 32 (ALU operands); o_alu_sel 4; o_rd_addr 5; o_reg_write, o_mem_read, o_mem_write 1; o_store_data 32.

Function
REQ-005 SHALL capture all decode inputs on each rising clk into the stage register; one-cycle latency to outputs.
REQ-006 SHALL load a bubble (valid, reg_write, mem_read, mem_write, alu_sel, addresses, data all 0) when i_flush=1, i_valid=0 or o_stall=1.
REQ-007 i_flush SHALL override stall; o_stall SHALL be 0 while i_flush=1.
REQ-008 "rt used" SHALL mean i_use_imm=0 or i_mem_write=1; rs always used.
REQ-009 Load-use hazard: o_stall=1 (combinational) when stage register valid & mem_read & rd!=0 & rd matches i_rs_addr, or matches i_rt_addr with rt used, and i_valid=1.
REQ-010 Forwarded rs/rt value SHALL be: i_exmem_result if i_exmem_reg_write & i_exmem_rd!=0 & equal address; else i_memwb_result under same rule; else registered data. EX/MEM priority over MEM/WB.
REQ-011 Register 0 SHALL never be forwarded nor cause a stall.
REQ-012 o_op1 = forwarded rs; o_op2 = registered imm if use_imm else forwarded rt; o_store_data = forwarded rt.
REQ-013 o_alu_sel, o_rd_addr, o_reg_write, o_mem_read, o_mem_write, o_valid SHALL come directly from the stage register.
REQ-014 Back-to-back stalls SHALL repeat until the hazard clears; each stalled cycle inserts exactly one bubble.

Reset
REQ-015 rst_n=0 SHALL asynchronously clear every stage-register bit; outputs then read o_valid=0, controls 0, o_op1/o_op2/o_store_data 0, o_stall 0.
REQ-016 Reset mid-stall SHALL drop the stalled instruction; first edge after release captures live inputs.

Configuration
REQ-017 Macro FORWARDING_EN SHALL select the hazard strategy.
REQ-018 Defined: REQ-009/REQ-010 behaviour.
REQ-019 Undefined: no forwarding (operands = registered data); o_stall=1 whenever i_valid and a used source (nonzero) matches the rd of any valid writer in the stage register, EX/MEM (i_exmem_reg_write) or MEM/WB (i_memwb_reg_write); writeback-side inputs used only for comparison.

Verification
REQ-020 Reset: rst_n low mid-cycle with valid data held -> all outputs 0 immediately, o_stall 0.
REQ-021 Pass-through: i_rs_data=5, i_imm=7, i_use_imm=1, i_alu_sel=0010 -> next cycle o_op1=5, o_op2=7, o_alu_sel=0010, o_valid=1.
REQ-022 Forward priority (FORWARDING_EN): registered rs=r3 data 1, i_exmem_rd=3 result 0xAA, i_memwb_rd=3 result 0xBB -> o_op1=0xAA; drop exmem write -> 0xBB; rs=r0 -> registered value.
REQ-023 Load-use: lw r4 in stage, incoming add rs=r4 -> o_stall=1 one cycle, next o_valid=0; following cycle add captured, o_stall=0.
REQ-024 Flush vs stall: load-use condition with i_flush=1 -> o_stall=0, bubble captured.
REQ-025 No FORWARDING_EN: add r5 writer in EX/MEM, incoming rs=r5 -> o_stall held until i_exmem/i_memwb no longer write r5.
